// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache-to-AXI bridge: FSM state encodings,
// AXI size/burst codes and default transaction IDs.
package cache_axi_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_ADDR = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    RD_ADDR = ST_RD_ADDR,
    RD_DATA = ST_RD_DATA,
    WR_ADDR = ST_WR_ADDR,
    WR_RESP = ST_WR_RESP,
    DONE    = ST_DONE
  } state_t;

  localparam logic [1:0] SIZE_B     = 2'b00;
  localparam logic [1:0] SIZE_H     = 2'b01;
  localparam logic [1:0] SIZE_W     = 2'b10;
  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [3:0] DEF_INST_ID = 4'd0;
  localparam logic [3:0] DEF_DATA_ID = 4'd1;

  // The requester never issues size 2'b11; fold it onto a full word.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_W : size;
  endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// AXI3 single-beat bus between the bridge (master) and the SoC crossbar
// (slave). Carries the AR/R/AW/W/B channels.
interface cache_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_wstrb_gen.sv
// Write-strobe generator: maps request size and low address bits to the
// AXI byte-lane strobe.
//   size    in  2  00=byte, 01=half, 10/11=word
//   addr_lo in  2  byte address bits [1:0]
//   wstrb   out 4  byte-lane enables
module axi_wstrb_gen
  import cache_axi_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  always_comb begin
    wstrb = 4'b1111;
    case (size)
      SIZE_B:  wstrb = 4'b0001 << addr_lo;
      SIZE_H:  wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// Bridge from the cache req/dok protocol to single-beat AXI3 transactions.
// Arbitrates instruction and data ports with fixed priority, runs one
// transaction at a time and returns read data with a one-cycle dok pulse.
//   clk, reset                 clock, synchronous active-high reset
//   inst_cache_*               instruction port (always a word read)
//   data_cache_*               data port (read/write, byte/half/word)
//   stall_by_arbitrater        a request is outstanding without its dok
//   bus_err                    pulses with dok on non-OKAY RRESP/BRESP
//   bus                        AXI3 master port
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter bit         PRIO_DATA = 1'b1,
  parameter logic [3:0] INST_ID   = DEF_INST_ID,
  parameter logic [3:0] DATA_ID   = DEF_DATA_ID
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_cache_req,
  input  logic [31:0] inst_cache_addr,
  input  logic        inst_cache_wr,
  input  logic [1:0]  inst_cache_size,
  input  logic [31:0] inst_cache_wdata,
  output logic [31:0] inst_cache_rdata,
  output logic        inst_cache_dok,

  input  logic        data_cache_req,
  input  logic [31:0] data_cache_addr,
  input  logic        data_cache_wr,
  input  logic [1:0]  data_cache_size,
  input  logic [31:0] data_cache_wdata,
  output logic [31:0] data_cache_rdata,
  output logic        data_cache_dok,

  output logic        stall_by_arbitrater,
  output logic        bus_err,

  cache_axi_bridge_if.master bus
);

  state_t      state;
  logic        sel_data;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic [1:0]  resp_q;
  logic        aw_done;
  logic        w_done;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;
  logic [3:0]  wstrb_w;

  logic grant_data;
  logic aw_fire;
  logic w_fire;
  logic aw_all;
  logic w_all;

  assign grant_data = data_cache_req & (PRIO_DATA | ~inst_cache_req);
  assign aw_fire    = bus.awvalid & bus.awready;
  assign w_fire     = bus.wvalid & bus.wready;
  assign aw_all     = aw_done | aw_fire;
  assign w_all      = w_done | w_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sel_data     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      resp_q       <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (grant_data) begin
            sel_data <= 1'b1;
            addr_q   <= data_cache_addr;
            size_q   <= norm_size(data_cache_size);
            wdata_q  <= data_cache_wdata;
            state    <= data_cache_wr ? WR_ADDR : RD_ADDR;
          end else if (inst_cache_req) begin
            sel_data <= 1'b0;
            addr_q   <= inst_cache_addr;
            size_q   <= SIZE_W;
            state    <= RD_ADDR;
          end
        end
        RD_ADDR: if (bus.arready) state <= RD_DATA;
        RD_DATA: begin
          if (bus.rvalid) begin
            resp_q <= bus.rresp;
            if (sel_data) data_rdata_q <= bus.rdata;
            else          inst_rdata_q <= bus.rdata;
            state <= DONE;
          end
        end
        WR_ADDR: begin
          // AW and W complete independently in any order; leave once both have.
          if (aw_all && w_all) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_RESP;
          end else begin
            aw_done <= aw_all;
            w_done  <= w_all;
          end
        end
        WR_RESP: begin
          if (bus.bvalid) begin
            resp_q <= bus.bresp;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  axi_wstrb_gen u_wstrb (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .wstrb   (wstrb_w)
  );

  assign bus.arid    = sel_data ? DATA_ID : INST_ID;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = '0;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = BURST_INCR;
  assign bus.arlock  = '0;
  assign bus.arcache = '0;
  assign bus.arprot  = '0;
  assign bus.arvalid = (state == RD_ADDR);
  assign bus.rready  = (state == RD_DATA);

  assign bus.awid    = DATA_ID;
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = '0;
  assign bus.awsize  = {1'b0, size_q};
  assign bus.awburst = BURST_INCR;
  assign bus.awlock  = '0;
  assign bus.awcache = '0;
  assign bus.awprot  = '0;
  assign bus.awvalid = (state == WR_ADDR) & ~aw_done;

  assign bus.wid     = DATA_ID;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_w;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = (state == WR_ADDR) & ~w_done;
  assign bus.bready  = (state == WR_RESP);

  assign inst_cache_dok   = (state == DONE) & ~sel_data;
  assign data_cache_dok   = (state == DONE) & sel_data;
  assign inst_cache_rdata = inst_rdata_q;
  assign data_cache_rdata = data_rdata_q;
  assign bus_err          = (state == DONE) & (|resp_q);

  assign stall_by_arbitrater = (inst_cache_req & ~inst_cache_dok) |
                               (data_cache_req & ~data_cache_dok);

  // Instruction write fields and AXI IDs/rlast are intentionally not consumed.
  logic unused_ok;
  assign unused_ok = &{1'b0, inst_cache_wr, inst_cache_size, inst_cache_wdata,
                       bus.rid, bus.rlast, bus.bid};

endmodule
